// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sequencing two 4-phase req/ack requesters onto the 256x8 data memory.
// Latency: grant edge -> one ACCESS cycle of strobes -> one RESP cycle of ack; three cycles grant to grant.
// Backpressure: requests wait while busy; a requester is re-eligible only after its req is seen low.
module datamem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              rr_ptr;
    logic              wait_low0, wait_low1;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              elig0, elig1;
    logic              grant, grant_id;

    // A requester still holding req after its ack must be seen low before it is eligible again.
    assign elig0 = req0 & ~wait_low0;
    assign elig1 = req1 & ~wait_low1;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 | elig1) begin
                    grant     = 1'b1;
                    grant_id  = (elig0 & elig1) ? rr_ptr : elig1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            wait_low0 <= 1'b0;
            wait_low1 <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gnt_id    <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state <= state_nxt;

            if (grant) begin
                gnt_id    <= grant_id;
                lat_we    <= grant_id ? we1    : we0;
                lat_addr  <= grant_id ? addr1  : addr0;
                lat_wdata <= grant_id ? wdata1 : wdata0;
            end

            if (state == ACCESS && !lat_we) begin
                if (gnt_id) rdata1 <= mem_read_data;
                else        rdata0 <= mem_read_data;
            end

            if (state == RESP) rr_ptr <= ~gnt_id;

            if (state == RESP && !gnt_id) wait_low0 <= 1'b1;
            else if (!req0)               wait_low0 <= 1'b0;

            if (state == RESP && gnt_id)  wait_low1 <= 1'b1;
            else if (!req1)               wait_low1 <= 1'b0;
        end
    end

    // Buses follow the latched request, so they only change at a grant and hold otherwise.
    assign mem_read_addr  = lat_addr;
    assign mem_write_addr = lat_addr;
    assign mem_write_data = lat_wdata;
    assign mem_write      = (state == ACCESS) &  lat_we;
    assign mem_read       = (state == ACCESS) & ~lat_we;
    assign ack0           = (state == RESP) & ~gnt_id;
    assign ack1           = (state == RESP) &  gnt_id;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: behavioural memory, two requester drivers and an ack scoreboard.
module tb_datamem_arbiter;

    typedef struct packed {
        logic       we;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       ack0, ack1, mem_write, mem_read, busy, gnt_id;
    logic [7:0] rdata0, rdata1, mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    logic [7:0] last_rd [2];
    exp_t       exp_q0[$], exp_q1[$];
    bit         grant_log[$];
    int         checks = 0;
    int         errors = 0;
    logic       prev_ack0 = 1'b0, prev_ack1 = 1'b0;

    always #5 clk = ~clk;

    datamem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data), .busy(busy), .gnt_id(gnt_id)
    );

    assign mem_read_data = mem[mem_read_addr];
    always @(posedge clk) if (mem_write) mem[mem_write_addr] = mem_write_data;

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (mem_read || mem_write) begin
                checks++;
                if (mem_read && mem_write) begin
                    errors++;
                    $display("FAIL strobe_overlap: mem_read=%b mem_write=%b, required not both", mem_read, mem_write);
                end
            end
            if (ack0) begin
                checks++;
                if (prev_ack0 || ack1 || gnt_id !== 1'b0) begin
                    errors++;
                    $display("FAIL ack0_shape: prev=%b ack1=%b gnt_id=%b, required 0/0/0", prev_ack0, ack1, gnt_id);
                end
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL ack0_unexpected: ack0=1 with no outstanding transaction");
                end else begin
                    e = exp_q0.pop_front();
                    if (rdata0 !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata0: got %h, required %h (we=%b)", rdata0, e.rdata, e.we);
                    end
                end
                grant_log.push_back(1'b0);
            end
            if (ack1) begin
                checks++;
                if (prev_ack1 || ack0 || gnt_id !== 1'b1) begin
                    errors++;
                    $display("FAIL ack1_shape: prev=%b ack0=%b gnt_id=%b, required 0/0/1", prev_ack1, ack0, gnt_id);
                end
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL ack1_unexpected: ack1=1 with no outstanding transaction");
                end else begin
                    e = exp_q1.pop_front();
                    if (rdata1 !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata1: got %h, required %h (we=%b)", rdata1, e.rdata, e.we);
                    end
                end
                grant_log.push_back(1'b1);
            end
        end
        prev_ack0 = ack0;
        prev_ack1 = ack1;
    end

    task automatic push_exp(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.we = we;
        if (we) begin
            shadow[a] = d;
            e.rdata   = last_rd[id];
        end else begin
            e.rdata     = shadow[a];
            last_rd[id] = shadow[a];
        end
        if (id) exp_q1.push_back(e);
        else    exp_q0.push_back(e);
    endtask

    task automatic set_req(input bit id, input bit r, input bit we, input logic [7:0] a, input logic [7:0] d);
        if (id) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
        else    begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    task automatic do_txn(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d);
        bit seen = 1'b0;
        push_exp(id, we, a, d);
        @(posedge clk); #1;
        set_req(id, 1'b1, we, a, d);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = id ? ack1 : ack0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL txn_timeout: id=%0d addr=%h no ack within 40 cycles", id, a);
        end
        @(posedge clk); #1;
        set_req(id, 1'b0, we, a, d);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({ack0, ack1, mem_write, mem_read, busy, gnt_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack0/ack1/wr/rd/busy/gnt=%b, required 000000",
                     {ack0, ack1, mem_write, mem_read, busy, gnt_id});
        end
        checks++;
        if ({rdata0, rdata1, mem_read_addr, mem_write_addr, mem_write_data} !== 40'h0) begin
            errors++;
            $display("FAIL reset_data: buses=%h, required 0", {rdata0, rdata1, mem_read_addr, mem_write_addr, mem_write_data});
        end
        apply_reset();
    endtask

    task automatic test_write_read();
        bit seen = 1'b0;
        push_exp(1'b0, 1'b1, 8'h10, 8'hA5);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_write, mem_read, ack0, mem_write_addr, mem_write_data} !== {3'b100, 8'h10, 8'hA5}) begin
            errors++;
            $display("FAIL wr_access: wr/rd/ack0=%b addr=%h data=%h, required 100 10 a5",
                     {mem_write, mem_read, ack0}, mem_write_addr, mem_write_data);
        end
        @(negedge clk);
        checks++;
        if ({mem_write, mem_read, ack0, busy} !== 4'b0011) begin
            errors++;
            $display("FAIL wr_resp: wr/rd/ack0/busy=%b, required 0011", {mem_write, mem_read, ack0, busy});
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack0, busy, mem[8'h10]} !== {2'b00, 8'hA5}) begin
            errors++;
            $display("FAIL wr_done: ack0/busy=%b mem[10]=%h, required 00 a5", {ack0, busy}, mem[8'h10]);
        end
        // Read back with the same cycle-level expectations.
        push_exp(1'b0, 1'b0, 8'h10, 8'h00);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem_read;
        end
        checks++;
        if (!seen || mem_read_addr !== 8'h10 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rd_access: seen=%b addr=%h wr=%b, required 1 10 0", seen, mem_read_addr, mem_write);
        end
        @(negedge clk);
        checks++;
        if ({mem_read, ack0, rdata0} !== {2'b01, 8'hA5}) begin
            errors++;
            $display("FAIL rd_resp: rd/ack0=%b rdata0=%h, required 01 a5", {mem_read, ack0}, rdata0);
        end
        @(posedge clk); #1;
        req0 = 1'b0;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        grant_log.delete();
        fork
            do_txn(1'b0, 1'b0, 8'h10, 8'h00);
            do_txn(1'b1, 1'b0, 8'h80, 8'h00);
        join
        checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1) begin
            errors++;
            $display("FAIL simul_order: %0d grants, first=%0d, required 2 grants in order 0,1",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 1'b1);
        end
    endtask

    task automatic test_contention();
        int bad = 0;
        grant_log.delete();
        fork
            for (int i = 0; i < 8; i++)
                if (i % 2 == 0) do_txn(1'b0, 1'b1, 8'h20 + 8'(i), 8'h50 + 8'(i));
                else            do_txn(1'b0, 1'b0, 8'h20 + 8'(i - 1), 8'h00);
            for (int j = 0; j < 8; j++)
                if (j % 2 == 0) do_txn(1'b1, 1'b1, 8'h90 + 8'(j), 8'hC0 + 8'(j));
                else            do_txn(1'b1, 1'b0, 8'h90 + 8'(j - 1), 8'h00);
        join
        for (int k = 1; k < grant_log.size(); k++)
            if (grant_log[k] == grant_log[k-1]) bad++;
        checks++;
        if (grant_log.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL contention_alt: %0d grants with %0d repeats, required 16 strictly alternating",
                     grant_log.size(), bad);
        end
    endtask

    task automatic test_held();
        bit seen = 1'b0;
        int extra = 0;
        push_exp(1'b1, 1'b0, 8'h92, 8'h00);
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 8'h92, 8'h00);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ack1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL held_first: no ack1 within 20 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack1 || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL held_regrant: %0d busy/ack cycles while req1 held, required 0", extra);
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        push_exp(1'b1, 1'b0, 8'h92, 8'h00);
        @(posedge clk); #1;
        req1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ack1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL held_second: no ack1 after req1 dropped and re-raised");
        end
        @(posedge clk); #1;
        req1 = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        bit seen = 1'b0;
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b1, 8'h40, 8'h5A);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_write;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_setup: mem_write never seen");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_write, mem_read, busy, ack0, ack1, gnt_id} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: wr/rd/busy/ack0/ack1/gnt=%b, required 000000",
                     {mem_write, mem_read, busy, ack0, ack1, gnt_id});
        end
        checks++;
        if ({mem_read_addr, mem_write_addr, mem_write_data, rdata0, rdata1} !== 40'h0) begin
            errors++;
            $display("FAIL rst_mid_data: buses=%h, required 0", {mem_read_addr, mem_write_addr, mem_write_data, rdata0, rdata1});
        end
        apply_reset();
        checks++;
        if (mem[8'h40] !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_lost_write: mem[40]=%h, required 00", mem[8'h40]);
        end
        grant_log.delete();
        do_txn(1'b1, 1'b0, 8'h90, 8'h00);
        checks++;
        if (grant_log.size() != 1 || rdata1 !== 8'hC0) begin
            errors++;
            $display("FAIL rst_mid_after: %0d grants rdata1=%h, required 1 c0", grant_log.size(), rdata1);
        end
    endtask

    task automatic test_rdata_hold();
        do_txn(1'b0, 1'b1, 8'h30, 8'h3C);
        do_txn(1'b0, 1'b0, 8'h30, 8'h00);
        do_txn(1'b0, 1'b1, 8'h30, 8'h77);
        @(negedge clk);
        checks++;
        if (rdata0 !== 8'h3C || mem[8'h30] !== 8'h77) begin
            errors++;
            $display("FAIL rdata_hold: rdata0=%h mem[30]=%h, required 3c 77", rdata0, mem[8'h30]);
        end
        do_txn(1'b0, 1'b0, 8'h30, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_contention();
        test_held();
        test_reset_mid_access();
        test_rdata_hold();
        repeat (4) @(posedge clk);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expected acks never seen", exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 256x8 data memory.
- Requester 0 is the APB slave side; requester 1 is the I2C controller side.
- Grants one requester at a time using round-robin, drives the memory strobe and address/data buses for exactly one cycle, and returns read data with a single-cycle ack.
- Uses a 4-phase req/ack handshake so registered requesters never double-issue.

Parameters:
- ADDR_W, 8, memory address width (256 locations).
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 transaction request, level.
- we0  in  1  requester 0: 1 = write, 0 = read; valid while req0 = 1.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  requester 0 completion pulse, one cycle.
- rdata0  out  DATA_W  requester 0 read data, valid when ack0 = 1 on a read.
- req1, we1, addr1, wdata1, ack1, rdata1  same as above, for requester 1.
- mem_read_addr  out  ADDR_W  memory read address.
- mem_write_addr  out  ADDR_W  memory write address.
- mem_write_data  out  DATA_W  memory write data.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_read_data  in  DATA_W  memory read data.
- busy  out  1  high when the state is not IDLE.
- gnt_id  out  1  id of the current or last granted requester.

Behaviour:
- Reset values (applied asynchronously while rst_n = 0):
  - state = IDLE.
  - All outputs = 0, including ack0/1, rdata0/1, mem_* strobes and buses, busy and gnt_id.
  - Round-robin pointer = 0, so requester 0 has priority.
  - wait_low0/1 = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - A requester is eligible when reqN = 1 and wait_lowN = 0.
  - With no eligible requester, stay in IDLE.
  - With one eligible requester, grant it.
  - With both eligible, grant the requester the pointer favours.
  - On grant: latch weN, addrN and wdataN into internal registers; set gnt_id; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_read_addr = mem_write_addr = latched address; mem_write_data = latched wdata.
  - If latched we = 1: mem_write = 1, mem_read = 0. Otherwise mem_read = 1, mem_write = 0.
  - Next state is RESP.
- RESP (exactly one cycle):
  - ack of the granted requester = 1.
  - On reads, the granted requester's rdata is loaded with mem_read_data on the ACCESS->RESP edge and holds until its next read completes.
  - On writes, rdata is unchanged.
  - The pointer moves to the other requester.
  - wait_low of the granted requester is set.
  - Next state is IDLE.
- Latency: req sampled high in IDLE at edge N -> strobes high during cycle N..N+1 -> ack high during cycle N+1..N+2. Three cycles from grant to next possible grant.
- Handshake:
  - reqN and its payload must be held stable until ackN is seen.
  - wait_lowN clears on any edge where reqN = 0.
  - A req held high after ack is never re-granted until it has been seen low for at least one edge.
  - Changing payload while req is pending, before grant, is allowed; the value latched at grant wins.
- Strobes are only ever high in ACCESS. mem_read and mem_write are never high together. Bus outputs hold their last value outside ACCESS.
- Requests arriving during ACCESS or RESP wait. The other requester keeps its request pending and is served next, which guarantees no starvation.
- A requester dropping req before grant cancels its request, with no ack.
- Reset mid-operation: strobes and ack drop immediately and no partial ack is issued. The memory write is lost if reset asserts during ACCESS before the edge.
- Address wrap: addresses are used as given; there is no increment logic.

Test Plan:
- Single write then read: req0 write addr 0x10 data 0xA5 -> mem_write for exactly 1 cycle with mem_write_addr = 0x10, ack0 two edges after grant. Then req0 read 0x10 -> rdata0 = 0xA5 when ack0 = 1, mem_read for 1 cycle.
- Simultaneous requests out of reset: req0 and req1 both read -> requester 0 acked first, requester 1 granted at the next IDLE. gnt_id sequence 0, 1. No overlapping strobes.
- Continuous contention: both reqs toggling 4-phase for 8 transactions each -> grants strictly alternate 0, 1, 0, 1 and every ack is a single cycle.
- Held request: req1 kept high for 10 cycles after ack1 -> exactly one transaction. Drop req1 for 1 cycle and raise it again -> second transaction issued.
- Reset mid-ACCESS: assert rst_n = 0 during the write cycle -> mem_write, busy and ack drop at once, and all outputs return to 0. After release, req1 alone is granted normally.
- Write does not disturb rdata: rdata0 = 0x3C from a prior read, then a req0 write of 0x77 -> rdata0 stays 0x3C.
